// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - bundle of receiver, consumer and status signals for uart_rx_ctrl
//
// Purpose: groups everything except clk/rst_n that crosses the uart_rx_ctrl boundary.
// Signals:
//   rx_data[7:0], rx_status       : from the 16x UART receiver
//   out_data[7:0], out_valid      : show-ahead FIFO head to the consumer
//   out_ready                     : consumer accepts the head byte
//   level[AW:0]                   : bytes currently held
//   overrun, drop_cnt[7:0]        : sticky drop flag and saturating drop count
//   clr_err                       : clears overrun and drop_cnt
//   idle_pulse                    : one-cycle end-of-burst strobe
// Modports: slave = the controller, master = the environment driving it.

interface uart_rx_ctrl_if #(
  parameter int AW = 3
) ();
  logic [7:0]  rx_data;
  logic        rx_status;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [AW:0] level;
  logic        overrun;
  logic [7:0]  drop_cnt;
  logic        clr_err;
  logic        idle_pulse;

  modport slave (
    input  rx_data, rx_status, out_ready, clr_err,
    output out_data, out_valid, level, overrun, drop_cnt, idle_pulse
  );

  modport master (
    output rx_data, rx_status, out_ready, clr_err,
    input  out_data, out_valid, level, overrun, drop_cnt, idle_pulse
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-side byte queue with overrun tracking and idle timeout
//
// Purpose: captures each good frame from the receiver (rising edge of rx_status), queues the
// byte in a show-ahead FIFO drained by a valid/ready handshake, counts bytes dropped on a
// full FIFO, and optionally flags end-of-burst after IDLE_CYCLES clocks with no new byte.
// Ports:
//   clk        : 16x oversampling clock shared with the receiver
//   rst_n      : synchronous active-low reset
//   bus        : uart_rx_ctrl_if.slave (rx_data/rx_status in, out_* handshake, level,
//                overrun, drop_cnt, clr_err, idle_pulse)
// Parameters: DEPTH (power of two, >= 2), AW = log2(DEPTH), IDLE_CYCLES (1..65535).
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle timer; otherwise
// idle_pulse is tied low.

module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int IDLE_CYCLES = 320
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_ctrl_if.slave  bus
);

  localparam int LW = AW + 1;

  // Edge detect on rx_status; resetting rs_q to 1 means a line already high at reset
  // release never looks like a completed frame.
  logic rs_q, rs_d;
  logic cap;

  // FIFO state
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  // Error state
  logic          overrun_q, overrun_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    drop_base;

  // Handshake decode
  logic out_valid;
  logic full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  assign cap       = bus.rx_status & ~rs_q;
  assign out_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign do_pop    = out_valid & bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign do_push   = cap & (~full | do_pop);
  assign do_drop   = cap & full & ~do_pop;

  always_comb begin
    rs_d       = bus.rx_status;
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    mem_d      = mem_q;
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    drop_base  = drop_cnt_q;

    if (do_push) begin
      mem_d[tail_q] = bus.rx_data;
      tail_d        = tail_q + AW'(1);
    end
    if (do_pop) begin
      head_d = head_q + AW'(1);
    end
    level_d = level_q + LW'(do_push) - LW'(do_pop);

    // clr_err and a drop in the same cycle: the clear applies first, then the drop
    // counts from zero, so the drop is never lost.
    if (bus.clr_err) begin
      overrun_d  = 1'b0;
      drop_cnt_d = '0;
      drop_base  = '0;
    end
    if (do_drop) begin
      overrun_d  = 1'b1;
      drop_cnt_d = (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q       <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rs_q       <= rs_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: out_data is gated by out_valid, so stale entries never show.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[head_q] : 8'h00;
  assign bus.level     = level_q;
  assign bus.overrun   = overrun_q;
  assign bus.drop_cnt  = drop_cnt_q;

`ifdef UART_RX_TIMEOUT_EN
  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } tmr_state_e;

  localparam logic [15:0] LAST = 16'(IDLE_CYCLES - 1);

  tmr_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        idle_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts cycles since the capture cycle minus one, so the strobe lands exactly
  // IDLE_CYCLES clocks after the last capture. A capture always wins over the strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_pulse = 1'b0;
    if (cap) begin
      state_d = ARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (cnt_q == LAST) begin
            idle_pulse = 1'b1;
            state_d    = DISARMED;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = DISARMED;
        end
      endcase
    end
  end

  assign bus.idle_pulse = idle_pulse;
`else
  assign bus.idle_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed scoreboard bench for uart_rx_ctrl

module tb_uart_rx_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_ctrl_if #(.AW(3)) bus ();

  uart_rx_ctrl #(
    .DEPTH      (8),
    .AW         (3),
    .IDLE_CYCLES(320)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_TIMEOUT_EN
  localparam int EXP_IDLE_PULSES = 1;
`else
  localparam int EXP_IDLE_PULSES = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int last_cap = 0;
  int pulse_base = 0;

  logic [7:0] q[$];
  int exp_drops = 0;
  bit exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.idle_pulse === 1'b1) begin
      pulses = pulses + 1;
      last_pulse = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One receiver frame: rx_status low while in progress, then the stop bit value.
  // rdy/clr are asserted in the capture cycle. Returns one cycle after capture.
  task automatic frame(input logic [7:0] b, input bit stop, input bit rdy, input bit clr);
    bus.rx_status = 1'b0;
    tick();
    tick();
    bus.rx_data = b;
    tick();
    bus.rx_status = stop;
    bus.out_ready = rdy;
    bus.clr_err   = clr;
    last_cap = cyc;
    @(negedge clk);
    if (rdy && q.size() > 0) begin
      check("cap_pop_data", bus.out_data, q[0]);
      void'(q.pop_front());
    end
    if (clr) begin
      exp_drops = 0;
      exp_ovr   = 1'b0;
    end
    if (stop) begin
      if (q.size() < 8) q.push_back(b);
      else begin
        exp_ovr = 1'b1;
        if (exp_drops < 255) exp_drops++;
      end
    end
    tick();
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("drain_valid", bus.out_valid, 1);
      check("drain_data", bus.out_data, q.pop_front());
      bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_level"}, bus.level, q.size());
    check({tag, "_valid"}, bus.out_valid, (q.size() > 0) ? 1 : 0);
    check({tag, "_overrun"}, bus.overrun, exp_ovr);
    check({tag, "_drop_cnt"}, bus.drop_cnt, exp_drops);
  endtask

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_status = 1'b1;
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state, and no capture of the already-high rx_status
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_level", bus.level, 0);
    repeat (3) tick();
    check_state("rst_nocap");
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_idle", bus.idle_pulse, 0);

    // Single frame, visible one cycle after capture, popped next cycle
    frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check_state("single");
    drain(1);
    check_state("single_empty");

    // Framing error byte is discarded
    frame(8'h33, 1'b0, 1'b0, 1'b0);
    frame(8'h44, 1'b1, 1'b0, 1'b0);
    check_state("ferr");
    drain(1);

    // Fill to full plus one: overrun
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
    check_state("fill");
    drain(8);
    check_state("fill_drained");
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    exp_drops = 0;
    exp_ovr   = 1'b0;
    check_state("clr");

    // Full with a pop in the capture cycle: no overrun
    for (int i = 1; i <= 8; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
    frame(8'h0A, 1'b1, 1'b1, 1'b0);
    check_state("full_pop");
    drain(8);

    // Clear and drop in the same cycle: drop wins
    for (int i = 0; i < 8; i++) frame(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0);
    frame(8'h29, 1'b1, 1'b0, 1'b0);
    frame(8'h2A, 1'b1, 1'b0, 1'b0);
    check_state("two_drops");
    frame(8'h2B, 1'b1, 1'b0, 1'b1);
    check_state("clr_vs_drop");
    drain(8);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    exp_drops = 0;
    exp_ovr   = 1'b0;

    // Idle timeout: two bytes 160 clocks apart, one strobe 320 after the second
    repeat (400) tick();
    pulse_base = pulses;
    frame(8'hA1, 1'b1, 1'b0, 1'b0);
    repeat (157) tick();
    frame(8'hA2, 1'b1, 1'b0, 1'b0);
    repeat (400) tick();
    check("idle_count", pulses - pulse_base, EXP_IDLE_PULSES);
`ifdef UART_RX_TIMEOUT_EN
    check("idle_cycle", last_pulse, last_cap + 320);
`else
    check("idle_never", pulses, 0);
`endif
    check_state("idle_level");
    drain(2);
    check_state("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller placed between the 16x-oversampling UART receiver and its byte consumer, such as the CPU I/O port or the command decoder. It detects completed good frames from the receiver's `rx_status`/`rx_data` outputs and queues the bytes in a small show-ahead FIFO. The queue is drained through a valid/ready handshake. The block also tracks overrun and can flag end-of-burst with an idle-line timeout.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `AW`, default 3: log2(`DEPTH`).
- `IDLE_CYCLES`, default 320: clocks without a new byte before `idle_pulse`. 320 is two character times at 16x oversampling. Range 1..65535.

Ports:
- `clk` input, 1 bit: 16x-oversampling clock, the same clock as the receiver.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `rx_data` input, 8 bits: receiver data byte.
- `rx_status` input, 1 bit: receiver status. It is 0 while a frame is in progress and takes the stop-bit value at the end of the frame.
- `out_data` output, 8 bits: FIFO head byte. Valid only while `out_valid` is 1.
- `out_valid` output, 1 bit: FIFO is not empty.
- `out_ready` input, 1 bit: consumer accepts the head byte.
- `level` output, `AW`+1 bits: number of bytes held.
- `overrun` output, 1 bit: sticky; a byte was dropped because the FIFO was full.
- `drop_cnt` output, 8 bits: dropped-byte count, saturating at 255.
- `clr_err` input, 1 bit: clears `overrun` and `drop_cnt`.
- `idle_pulse` output, 1 bit: one-cycle end-of-burst strobe.

## Operation
- Edge detect:
  - `rs_q` registers `rx_status` every cycle and resets to 1.
  - `cap = rx_status & ~rs_q`, combinational.
  - A high `rx_status` at reset release is therefore never captured.
  - A frame with stop bit 0 leaves `rx_status` at 0, so no capture happens and the byte is silently discarded.
- Push:
  - On `cap`, `rx_data` is written at the tail on the same clock edge.
  - `rx_data` is stable at that point, because the receiver updated it at least 16 clocks earlier.
- Pop:
  - Occurs when `out_valid & out_ready`; the head pointer advances.
  - `out_data` is driven from a register or memory read of the head pointer and is show-ahead.
- Pointers:
  - `AW`-bit head and tail pointers wrap modulo `DEPTH`.
  - `level` is tracked separately, from 0 to `DEPTH`.
  - Full means `level == DEPTH`; empty means `level == 0`.
- Simultaneous push and pop:
  - Not full: both are performed and `level` is unchanged.
  - Full: the pop frees a slot, so the push is accepted, `level` stays at `DEPTH`, and there is no overrun.
  - Empty: only the push takes effect, because `out_valid` is 0.
- Overrun:
  - Occurs on a push while full with no pop. The byte is dropped and the FIFO is unchanged.
  - `overrun` is set to 1 and `drop_cnt` increments, saturating at 255.
- `clr_err`: clears both flags. If a drop happens in the same cycle, the drop wins: `overrun` is 1 and `drop_cnt` is 1.
- Idle timer (see Configuration):
  - States are DISARMED and ARMED.
  - `cap`: the timer goes to ARMED and the counter goes to 0.
  - While ARMED with no `cap`, the counter increments.
  - When the counter reaches `IDLE_CYCLES`-1, `idle_pulse` is 1 for that cycle and the state returns to DISARMED.
  - A `cap` in the terminal cycle takes priority: no pulse, and the timer re-arms.
- Reset with `rst_n` = 0 at a clock edge:
  - Pointers, `level`, and the timer go to 0 and DISARMED; `rs_q` goes to 1.
  - Any bytes in flight are discarded, and a frame that completes during reset is not captured.
- Reset values of outputs:
  - `out_valid` = 0, `level` = 0, `overrun` = 0, `drop_cnt` = 0, `idle_pulse` = 0.
  - `out_data` = 8'h00.

## Timing
- Capture cycle N: `rx_status` rises in cycle N. `out_valid` = 1 and `level` is updated from cycle N+1.
- Pop: the handshake completes at the edge ending the cycle. The next head byte, or `out_valid` = 0, is presented from the next cycle.
- Back-to-back pops: one per cycle.
- Pushes: at most one per 160 clocks at line rate. The FIFO is nonetheless correct for one push per cycle.
- `idle_pulse`: asserted in cycle N+`IDLE_CYCLES`, where N is the last capture cycle.
- `overrun`, `drop_cnt`: updated at the edge ending the dropping cycle and visible in the next cycle.

## Configuration
- `UART_RX_TIMEOUT_EN` defined: the idle timer and `idle_pulse` are implemented as described.
- `UART_RX_TIMEOUT_EN` not defined: the timer logic is omitted and `idle_pulse` is tied to 0. All other behaviour is identical.

## Test plan
- Reset: after `rst_n` is low for 2 cycles with `rx_status` held at 1, release → `out_valid` = 0, `level` = 0, and no capture occurs.
- Single frame: 0x5A with a good stop bit → `out_valid` is 1 one cycle after `rx_status` rises, `out_data` = 0x5A, `level` = 1. With `out_ready` = 1, `level` = 0 the next cycle.
- Framing error: 0x33 with stop bit 0, then 0x44 with a good stop bit → only 0x44 is queued.
- Fill and overrun:
  - Write 9 bytes 0x01..0x09 with `out_ready` = 0 → `level` = 8, `overrun` = 1, `drop_cnt` = 1.
  - Drain → bytes 0x01..0x08 in order.
  - `clr_err` → both flags are 0.
- Full with simultaneous pop: at `level` = 8, pulse `out_ready` in the capture cycle of 0x0A → no overrun, `level` stays at 8, and the last byte drained is 0x0A.
- Idle timeout (macro defined): two bytes 160 clocks apart → exactly one `idle_pulse`, 320 cycles after the second capture. Macro undefined → `idle_pulse` is always 0.
